// File: rtl/seg_scan_controller.sv
// Time-multiplexed scan controller for NUM_DIGITS common-anode digits sharing one
// 7-segment decoder; double-buffered display value swapped only at frame boundaries.
module seg_scan_controller #(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL_CYC  = 50000,
    parameter int BLANK_CYC  = 500
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      lz_en,
    input  logic                      load_valid,
    input  logic [4*NUM_DIGITS-1:0]   load_data,
    output logic                      load_ready,
    output logic [3:0]                code,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_tick
);
    localparam int MAXC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int DW   = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   active_q, active_d;
    logic [DW-1:0]   pend_q, pend_d;
    logic            pend_full_q, pend_full_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [3:0]      code_q, code_d;
    logic            frame_tick_q, frame_tick_d;
    logic            load_ready_q, load_ready_d;
    logic            last_s;
    logic            frame_end_s;

    function automatic logic [3:0] nibble_at(input logic [DW-1:0] v, input logic [IW-1:0] d);
        logic [3:0] r;
        r = 4'h0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            r = (IW'(i) == d) ? v[4*i +: 4] : r;
        end
        return r;
    endfunction

    // A digit is blanked when it and every more-significant nibble are zero; digit 0 always shows.
    function automatic logic digit_suppressed(input logic [DW-1:0] v, input logic [IW-1:0] d);
        logic upper_zero;
        upper_zero = 1'b1;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            upper_zero = upper_zero & ~((i >= int'(d)) && (v[4*i +: 4] != 4'h0));
        end
        return (d != {IW{1'b0}}) && upper_zero;
    endfunction

    // Scan sequencing, buffer handshake/swap and next registered outputs.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        active_d    = active_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;

        last_s      = (state_q == ST_BLANK) ? (cnt_q == BLANK_LAST) : (cnt_q == DWELL_LAST);
        frame_end_s = en && (state_q == ST_SHOW) && (idx_q == IDX_LAST) && (cnt_q == DWELL_LAST);

        if (!en) begin
            state_d = ST_BLANK;
            idx_d   = {IW{1'b0}};
            cnt_d   = {CW{1'b0}};
        end else if (last_s) begin
            cnt_d = {CW{1'b0}};
            if (state_q == ST_BLANK) begin
                state_d = ST_SHOW;
            end else begin
                state_d = ST_BLANK;
                idx_d   = (idx_q == IDX_LAST) ? {IW{1'b0}} : idx_q + 1'b1;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // Swap and transfer are exclusive: a swap needs pending full, a transfer needs it empty.
        if (frame_end_s && pend_full_q) begin
            active_d    = pend_q;
            pend_full_d = 1'b0;
        end else if (load_valid && load_ready_q) begin
            pend_d      = load_data;
            pend_full_d = 1'b1;
        end else begin
            pend_full_d = pend_full_q;
        end

        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_d[i] = !((state_d == ST_SHOW) && (IW'(i) == idx_d) &&
                        !(lz_en && digit_suppressed(active_d, idx_d)));
        end
        code_d       = nibble_at(active_d, idx_d);
        frame_tick_d = (state_d == ST_SHOW) && (idx_d == IDX_LAST) && (cnt_d == DWELL_LAST);
        load_ready_d = !pend_full_d;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_BLANK;
            idx_q        <= {IW{1'b0}};
            cnt_q        <= {CW{1'b0}};
            active_q     <= {DW{1'b0}};
            pend_q       <= {DW{1'b0}};
            pend_full_q  <= 1'b0;
            an_q         <= {NUM_DIGITS{1'b1}};
            code_q       <= 4'h0;
            frame_tick_q <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            active_q     <= active_d;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
            an_q         <= an_d;
            code_q       <= code_d;
            frame_tick_q <= frame_tick_d;
            load_ready_q <= load_ready_d;
        end
    end

    assign an         = an_q;
    assign code       = code_q;
    assign frame_tick = frame_tick_q;
    assign load_ready = load_ready_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller (4 digits, dwell 3, blank 1): first-frame vector table,
// then a frame-position model feeding an expected-output scoreboard queue.
module tb_seg_scan_controller;
    localparam int ND  = 4;
    localparam int DWL = 3;
    localparam int BLK = 1;
    localparam int PER = DWL + BLK;
    localparam int FR  = ND * PER;

    logic          clk;
    logic          reset;
    logic          en;
    logic          lz_en;
    logic          load_valid;
    logic [15:0]   load_data;
    logic          load_ready;
    logic [3:0]    code;
    logic [3:0]    an;
    logic          frame_tick;

    typedef struct {
        logic [3:0] an;
        logic [3:0] code;
        logic       tick;
        logic       rdy;
    } exp_t;

    typedef struct {
        logic       en;
        logic [3:0] an;
        logic [3:0] code;
        logic       tick;
    } vec_t;

    exp_t        sb_q[$];
    vec_t        tbl[16];
    int          n_vec;
    int          n_bad;

    int          m_pos;
    logic [15:0] m_act;
    logic [15:0] m_pend;
    logic        m_full;

    seg_scan_controller #(
        .NUM_DIGITS(ND),
        .DWELL_CYC (DWL),
        .BLANK_CYC (BLK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .lz_en     (lz_en),
        .load_valid(load_valid),
        .load_data (load_data),
        .load_ready(load_ready),
        .code      (code),
        .an        (an),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Expected outputs from frame position and the model's display value.
    function automatic exp_t model_out(input logic lz);
        exp_t        e;
        int          digit;
        int          msd;
        logic        show;
        logic [3:0]  one;
        logic [15:0] sh;
        digit = m_pos / PER;
        show  = (m_pos % PER) >= BLK;
        msd   = 0;
        for (int i = 0; i < ND; i++) begin
            sh = m_act >> (4 * i);
            if (sh[3:0] != 4'h0) msd = i;
        end
        one    = 4'b0001;
        e.an   = (show && !(lz && digit > msd)) ? ~(one << digit) : 4'b1111;
        sh     = m_act >> (4 * digit);
        e.code = sh[3:0];
        e.tick = show && (m_pos == FR - 1);
        e.rdy  = !m_full;
        return e;
    endfunction

    task automatic check_exp(input exp_t e);
        chk("an", {12'h0, an}, {12'h0, e.an});
        chk("code", {12'h0, code}, {12'h0, e.code});
        chk("frame_tick", {15'h0, frame_tick}, {15'h0, e.tick});
        chk("load_ready", {15'h0, load_ready}, {15'h0, e.rdy});
    endtask

    task automatic step(input logic e, input logic lz, input logic lv, input logic [15:0] d);
        logic sw;
        logic tr;
        exp_t got;
        en         = e;
        lz_en      = lz;
        load_valid = lv;
        load_data  = d;
        sw = e && (m_pos == FR - 1) && m_full;
        tr = lv && !m_full;
        if (sw) begin
            m_act  = m_pend;
            m_full = 1'b0;
        end
        if (tr) begin
            m_pend = d;
            m_full = 1'b1;
        end
        m_pos = e ? (m_pos + 1) % FR : 0;
        sb_q.push_back(model_out(lz));
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check_exp(got);
    endtask

    task automatic idle(input int n, input logic lz);
        for (int k = 0; k < n; k++) step(1'b1, lz, 1'b0, 16'h0000);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        tbl[0]  = '{1'b1, 4'b1111, 4'h0, 1'b0};
        tbl[1]  = '{1'b1, 4'b1110, 4'h0, 1'b0};
        tbl[2]  = '{1'b1, 4'b1110, 4'h0, 1'b0};
        tbl[3]  = '{1'b1, 4'b1110, 4'h0, 1'b0};
        tbl[4]  = '{1'b1, 4'b1111, 4'h0, 1'b0};
        tbl[5]  = '{1'b1, 4'b1101, 4'h0, 1'b0};
        tbl[6]  = '{1'b1, 4'b1101, 4'h0, 1'b0};
        tbl[7]  = '{1'b1, 4'b1101, 4'h0, 1'b0};
        tbl[8]  = '{1'b1, 4'b1111, 4'h0, 1'b0};
        tbl[9]  = '{1'b1, 4'b1011, 4'h0, 1'b0};
        tbl[10] = '{1'b1, 4'b1011, 4'h0, 1'b0};
        tbl[11] = '{1'b1, 4'b1011, 4'h0, 1'b0};
        tbl[12] = '{1'b1, 4'b1111, 4'h0, 1'b0};
        tbl[13] = '{1'b1, 4'b0111, 4'h0, 1'b0};
        tbl[14] = '{1'b1, 4'b0111, 4'h0, 1'b0};
        tbl[15] = '{1'b1, 4'b0111, 4'h0, 1'b1};

        reset      = 1'b1;
        en         = 1'b1;
        lz_en      = 1'b0;
        load_valid = 1'b0;
        load_data  = 16'h0000;
        #23;
        chk("rst_an", {12'h0, an}, 16'h000F);
        chk("rst_code", {12'h0, code}, 16'h0000);
        chk("rst_tick", {15'h0, frame_tick}, 16'h0000);
        chk("rst_ready", {15'h0, load_ready}, 16'h0001);

        // First frame straight after reset release, against fixed vectors.
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) begin
            en = tbl[i].en;
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            chk("tbl_an", {12'h0, an}, {12'h0, tbl[i].an});
            chk("tbl_code", {12'h0, code}, {12'h0, tbl[i].code});
            chk("tbl_tick", {15'h0, frame_tick}, {15'h0, tbl[i].tick});
            chk("tbl_ready", {15'h0, load_ready}, 16'h0001);
        end
        m_pos  = FR - 1;
        m_act  = 16'h0000;
        m_pend = 16'h0000;
        m_full = 1'b0;

        // Mid-frame load held off until the boundary.
        idle(4, 1'b0);
        step(1'b1, 1'b0, 1'b1, 16'h1234);
        idle(2 * FR, 1'b0);

        // Second value offered while pending is full.
        step(1'b1, 1'b0, 1'b1, 16'hABCD);
        for (int k = 0; k < 3 * FR; k++) begin
            logic acc;
            acc = !m_full;
            step(1'b1, 1'b0, 1'b1, 16'h5678);
            if (acc) break;
        end
        idle(2 * FR, 1'b0);
        chk("swap_5678", m_act, 16'h5678);

        // Leading-zero suppression.
        step(1'b1, 1'b1, 1'b1, 16'h0050);
        idle(2 * FR, 1'b1);
        step(1'b1, 1'b1, 1'b1, 16'h0000);
        idle(2 * FR, 1'b1);
        idle(FR, 1'b0);

        // Enable dropped during SHOW of digit 2, then restored.
        for (int k = 0; k < FR && m_pos != 2 * PER + BLK + 1; k++) step(1'b1, 1'b0, 1'b0, 16'h0000);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, 16'h0000);
        idle(FR + 4, 1'b0);

        // Asynchronous reset with pending full; pending value must never appear.
        step(1'b1, 1'b0, 1'b1, 16'h9876);
        idle(2 * FR, 1'b0);
        step(1'b1, 1'b0, 1'b1, 16'h4321);
        idle(6, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_an", {12'h0, an}, 16'h000F);
        chk("arst_code", {12'h0, code}, 16'h0000);
        chk("arst_ready", {15'h0, load_ready}, 16'h0001);
        chk("arst_tick", {15'h0, frame_tick}, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b0;
        m_pos  = 0;
        m_act  = 16'h0000;
        m_pend = 16'h0000;
        m_full = 1'b0;
        #1;
        check_exp(model_out(1'b0));
        idle(3 * FR, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
